// File: rtl/key_expand_seq_if.sv
// Handshake bundle between the key-expansion engine and its consumer.
// The slave side is the engine; the master side drives start/key and accepts words.
interface key_expand_seq_if;
    logic           start;
    logic [0:255]   key_in;
    logic           busy;
    logic [0:31]    w_out;
    logic [5:0]     w_idx;
    logic           w_valid;
    logic           w_ready;
    logic           done;

    modport master (
        output start, key_in, w_ready,
        input  busy, w_out, w_idx, w_valid, done
    );

    modport slave (
        input  start, key_in, w_ready,
        output busy, w_out, w_idx, w_valid, done
    );
endinterface

// File: rtl/key_expand_seq.sv
// Sequential AES key-expansion engine: emits schedule words w[0..4*NR+3],
// one per valid/ready handshake, from a sliding window of the last NK words.
module key_expand_seq #(
    parameter int NK = 4
) (
    input  logic             clk,
    input  logic             rst,
    key_expand_seq_if.slave  bus
);
    localparam int NR   = NK + 6;
    localparam int LAST = 4 * NR + 3;

    // AES S-box, entry b at bits [8*b +: 8] (entry 0 leftmost).
    localparam logic [0:2047] SBOX = {
        256'h637c777bf26b6fc53001672bfed7ab76ca82c97dfa5947f0add4a2af9ca472c0,
        256'hb7fd9326363ff7cc34a5e5f171d8311504c723c31896059a071280e2eb27b275,
        256'h09832c1a1b6e5aa0523bd6b329e32f8453d100ed20fcb15b6acbbe394a4c58cf,
        256'hd0efaafb434d338545f9027f503c9fa851a3408f929d38f5bcb6da2110fff3d2,
        256'hcd0c13ec5f974417c4a77e3d645d197360814fdc222a908846eeb814de5e0bdb,
        256'he0323a0a4906245cc2d3ac629195e479e7c8376d8dd54ea96c56f4ea657aae08,
        256'hba78252e1ca6b4c6e8dd741f4bbd8b8a703eb5664803f60e613557b986c11d9e,
        256'he1f8981169d98e949b1e87e9ce5528df8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        KEY    = 2'd1,
        EXPAND = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [0:31]    win_q [NK];
    logic [0:31]    win_d [NK];
    logic [5:0]     idx_q, idx_d;
    logic [2:0]     phase_q, phase_d;   // i mod NK, tracked incrementally during EXPAND
    logic [0:7]     rcon_q, rcon_d;
    logic           done_q, done_d;

    logic [0:31]    key_word;
    logic [0:31]    temp;
    logic [0:31]    word;
    logic           xfer;

    function automatic logic [0:7] sbox(input logic [0:7] b);
        return SBOX[8 * int'(b) +: 8];
    endfunction

    function automatic logic [0:31] sub_word(input logic [0:31] w);
        logic [0:31] r;
        r = '0;
        for (int unsigned b = 0; b < 4; b++) begin
            r[8 * b +: 8] = sbox(w[8 * b +: 8]);
        end
        return r;
    endfunction

    assign bus.w_valid = (state_q != IDLE);
    assign bus.busy    = (state_q != IDLE);
    assign bus.w_out   = word;
    assign bus.w_idx   = idx_q;
    assign bus.done    = done_q;
    assign xfer        = (state_q != IDLE) && bus.w_ready;

    // Output word: raw key words in KEY, window oldest XOR transformed newest in EXPAND.
    always_comb begin
        key_word = '0;
        for (int unsigned k = 0; k < NK; k++) begin
            if (idx_q == 6'(k)) key_word = win_q[k];
        end
        temp = win_q[NK-1];
        if (phase_q == 3'd0) begin
            temp = sub_word({win_q[NK-1][8:31], win_q[NK-1][0:7]}) ^ {rcon_q, 24'h0};
        end else if (NK == 8 && phase_q == 3'd4) begin
            temp = sub_word(win_q[NK-1]);
        end
        case (state_q)
            KEY:     word = key_word;
            EXPAND:  word = win_q[0] ^ temp;
            default: word = '0;
        endcase
    end

    // Next-state: load key on start, step index per transfer, slide window during EXPAND.
    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        idx_d   = idx_q;
        phase_d = phase_q;
        rcon_d  = rcon_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    for (int unsigned k = 0; k < NK; k++) begin
                        win_d[k] = bus.key_in[32 * k +: 32];
                    end
                    idx_d   = '0;
                    phase_d = '0;
                    rcon_d  = 8'h01;
                    state_d = KEY;
                end
            end
            KEY: begin
                if (xfer) begin
                    idx_d = idx_q + 6'd1;
                    if (idx_q == 6'(NK - 1)) state_d = EXPAND;
                end
            end
            EXPAND: begin
                if (xfer) begin
                    for (int unsigned k = 0; k < NK - 1; k++) begin
                        win_d[k] = win_q[k+1];
                    end
                    win_d[NK-1] = word;
                    phase_d = (phase_q == 3'(NK - 1)) ? 3'd0 : phase_q + 3'd1;
                    if (phase_q == 3'd0) begin
                        rcon_d = {rcon_q[1:7], 1'b0} ^ (rcon_q[0] ? 8'h1b : 8'h00);
                    end
                    if (idx_q == 6'(LAST)) begin
                        idx_d   = '0;
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + 6'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            for (int unsigned k = 0; k < NK; k++) begin
                win_q[k] <= '0;
            end
            idx_q   <= '0;
            phase_q <= '0;
            rcon_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            idx_q   <= idx_d;
            phase_q <= phase_d;
            rcon_q  <= rcon_d;
            done_q  <= done_d;
        end
    end
endmodule

// File: tb/tb_key_expand_seq.sv
// Bench for key_expand_seq: three instances (NK=4/6/8) checked against a
// schedule computed from GF(2^8) arithmetic and the textbook expansion rule.
module tb_key_expand_seq;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    key_expand_seq_if if4();
    key_expand_seq_if if6();
    key_expand_seq_if if8();

    key_expand_seq #(.NK(4)) u4 (.clk(clk), .rst(rst), .bus(if4));
    key_expand_seq #(.NK(6)) u6 (.clk(clk), .rst(rst), .bus(if6));
    key_expand_seq #(.NK(8)) u8 (.clk(clk), .rst(rst), .bus(if8));

    logic           start_s [3];
    logic [0:255]   key_s   [3];
    logic           ready_s [3];
    logic [31:0]    wout_o  [3];
    logic [5:0]     idx_o   [3];
    logic           valid_o [3];
    logic           busy_o  [3];
    logic           done_o  [3];

    assign if4.start = start_s[0]; assign if4.key_in = key_s[0]; assign if4.w_ready = ready_s[0];
    assign if6.start = start_s[1]; assign if6.key_in = key_s[1]; assign if6.w_ready = ready_s[1];
    assign if8.start = start_s[2]; assign if8.key_in = key_s[2]; assign if8.w_ready = ready_s[2];
    assign wout_o[0] = if4.w_out; assign idx_o[0] = if4.w_idx; assign valid_o[0] = if4.w_valid;
    assign wout_o[1] = if6.w_out; assign idx_o[1] = if6.w_idx; assign valid_o[1] = if6.w_valid;
    assign wout_o[2] = if8.w_out; assign idx_o[2] = if8.w_idx; assign valid_o[2] = if8.w_valid;
    assign busy_o[0] = if4.busy;  assign done_o[0] = if4.done;
    assign busy_o[1] = if6.busy;  assign done_o[1] = if6.done;
    assign busy_o[2] = if8.busy;  assign done_o[2] = if8.done;

    int          errors = 0;
    int          checks = 0;
    logic [7:0]  sbox_m  [256];
    logic [31:0] model_w [3][60];
    logic [31:0] seen_w  [3][60];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = '0;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [15:0] d = {v, v};
        d = d << n;
        return d[15:8];
    endfunction

    task automatic build_sbox();
        for (int a = 0; a < 256; a++) begin
            logic [7:0] inv = '0;
            for (int b = 1; b < 256; b++) begin
                if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            end
            sbox_m[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] sub_m(input logic [31:0] w);
        return {sbox_m[w[31:24]], sbox_m[w[23:16]], sbox_m[w[15:8]], sbox_m[w[7:0]]};
    endfunction

    task automatic expand(input int d, input logic [0:255] key, input int nk);
        logic [7:0]  rc = 8'h01;
        logic [31:0] t;
        for (int i = 0; i < 4 * (nk + 6) + 4; i++) begin
            if (i < nk) begin
                model_w[d][i] = key[32 * i +: 32];
            end else begin
                t = model_w[d][i-1];
                if (i % nk == 0) begin
                    t  = sub_m({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                    rc = gmul(rc, 8'h02);
                end else if (nk == 8 && i % nk == 4) begin
                    t = sub_m(t);
                end
                model_w[d][i] = model_w[d][i-nk] ^ t;
            end
        end
    endtask

    function automatic logic [0:255] rnd256();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic rnd_ready(input int pct);
        return ($urandom_range(99) < pct);
    endfunction

    task automatic run(input int d, input int nk, input logic [0:255] key, input int pct,
                       input int poke_idx, input int rst_idx, input bit pre_started,
                       input bit chain, input logic [0:255] chain_key);
        int          last;
        int          n;
        int          cyc;
        bit          stalled;
        bit          fin;
        logic [31:0] pw;
        logic [5:0]  pi;
        expand(d, key, nk);
        last = 4 * (nk + 6) + 3;
        if (!pre_started) begin
            @(posedge clk); #1;
            key_s[d]   = key;
            start_s[d] = 1'b1;
        end
        @(posedge clk); #1;
        start_s[d] = 1'b0;
        ready_s[d] = rnd_ready(pct);
        n = 0; cyc = 0; stalled = 0; fin = 0; pw = '0; pi = '0;
        while (!fin && cyc < 400) begin
            @(negedge clk);
            cyc++;
            chk("w_valid", 32'(valid_o[d]), 32'd1);
            chk("busy", 32'(busy_o[d]), 32'd1);
            chk("done_early", 32'(done_o[d]), 32'd0);
            chk("w_idx", 32'(idx_o[d]), 32'(n));
            chk("w_out", wout_o[d], model_w[d][n]);
            if (stalled) begin
                chk("stall_w_out", wout_o[d], pw);
                chk("stall_w_idx", 32'(idx_o[d]), 32'(pi));
            end
            if (ready_s[d]) begin
                seen_w[d][n] = wout_o[d];
                if (n == last) fin = 1;
                n++;
                stalled = 0;
            end else begin
                stalled = 1;
                pw = wout_o[d];
                pi = idx_o[d];
            end
            if (rst_idx >= 0 && n == rst_idx) begin
                #1 rst = 1'b1;
                #1;
                chk("rst_w_valid", 32'(valid_o[d]), 32'd0);
                chk("rst_busy", 32'(busy_o[d]), 32'd0);
                chk("rst_done", 32'(done_o[d]), 32'd0);
                chk("rst_w_out", wout_o[d], 32'd0);
                chk("rst_w_idx", 32'(idx_o[d]), 32'd0);
                #1 rst = 1'b0;
                @(negedge clk);
                chk("post_rst_done", 32'(done_o[d]), 32'd0);
                chk("post_rst_valid", 32'(valid_o[d]), 32'd0);
                return;
            end
            @(posedge clk); #1;
            start_s[d] = (n == poke_idx);
            if (n == poke_idx) key_s[d] = rnd256();
            if (fin && chain) begin
                start_s[d] = 1'b1;
                key_s[d]   = chain_key;
            end
            ready_s[d] = rnd_ready(pct);
        end
        if (!fin) begin
            checks++;
            errors++;
            $error("FAIL timeout transfers=%0d required=%0d", n, last + 1);
            return;
        end
        @(negedge clk);
        chk("done_pulse", 32'(done_o[d]), 32'd1);
        chk("done_valid", 32'(valid_o[d]), 32'd0);
        chk("done_busy", 32'(busy_o[d]), 32'd0);
        chk("done_w_out", wout_o[d], 32'd0);
        chk("done_w_idx", 32'(idx_o[d]), 32'd0);
        chk("xfer_count", 32'(n), 32'(last + 1));
        if (pct == 100) chk("throughput_cycles", 32'(cyc), 32'(last + 1));
    endtask

    logic [0:255] k128;
    logic [0:255] k192;
    logic [0:255] k256;
    logic [0:255] kr;

    initial begin
        build_sbox();
        k128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
        k192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
        k256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
        for (int d = 0; d < 3; d++) begin
            start_s[d] = 1'b0;
            ready_s[d] = 1'b0;
            key_s[d]   = '0;
        end
        rst = 1'b1;
        #2;
        for (int d = 0; d < 3; d++) begin
            chk("reset_valid", 32'(valid_o[d]), 32'd0);
            chk("reset_busy", 32'(busy_o[d]), 32'd0);
            chk("reset_done", 32'(done_o[d]), 32'd0);
            chk("reset_w_out", wout_o[d], 32'd0);
            chk("reset_w_idx", 32'(idx_o[d]), 32'd0);
        end
        #10 rst = 1'b0;

        // T1: AES-128 known answer, full throughput
        run(0, 4, {k128[0:127], 128'hdeadbeef_0badf00d_12345678_9abcdef0}, 100, -1, -1, 0, 0, '0);
        chk("T1_w0", seen_w[0][0], 32'h2b7e1516);
        chk("T1_w3", seen_w[0][3], 32'h09cf4f3c);
        chk("T1_w4", seen_w[0][4], 32'ha0fafe17);
        chk("T1_w43", seen_w[0][43], 32'hb6630ca6);

        // T2: AES-192 known answer
        run(1, 6, k192, 100, -1, -1, 0, 0, '0);
        chk("T2_w6", seen_w[1][6], 32'hfe0c91f7);
        chk("T2_w51", seen_w[1][51], 32'h01002202);

        // T3: AES-256 known answer including SubWord-only step
        run(2, 8, k256, 100, -1, -1, 0, 0, '0);
        chk("T3_w8", seen_w[2][8], 32'h9ba35411);
        chk("T3_w12", seen_w[2][12], 32'ha8b09c1a);
        chk("T3_w59", seen_w[2][59], 32'h706c631e);

        // T4: random backpressure
        run(0, 4, k128, 50, -1, -1, 0, 0, '0);
        chk("T4_w43", seen_w[0][43], 32'hb6630ca6);

        // T5: start while busy ignored; start in done cycle launches a new run
        kr = rnd256();
        run(0, 4, k128, 100, 10, -1, 0, 1, kr);
        run(0, 4, kr, 70, -1, -1, 1, 0, '0);

        // T6: reset mid-run, then a clean rerun
        run(0, 4, k128, 100, -1, 20, 0, 0, '0);
        run(0, 4, k128, 100, -1, -1, 0, 0, '0);
        chk("T6_w43", seen_w[0][43], 32'hb6630ca6);

        // Random keys on every key length with backpressure
        for (int r = 0; r < 2; r++) begin
            run(0, 4, rnd256(), 60, -1, -1, 0, 0, '0);
            run(1, 6, rnd256(), 60, -1, -1, 0, 0, '0);
            run(2, 8, rnd256(), 60, -1, -1, 0, 0, '0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
